// File: rtl/otter_csr_pkg.sv
// Shared definitions for the machine-mode CSR / interrupt unit.
//   - CSR address map for the implemented registers
//   - bit positions of the architected fields inside mstatus / mie
//   - cause code loaded into mcause on an external-interrupt trap
//   - two-state trap FSM encoding
// Optional feature macro: CSR_MCAUSE_EN (mcause register present when defined).
package otter_csr_pkg;

  localparam logic [11:0] CSR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_MIE     = 12'h304;
  localparam logic [11:0] CSR_MTVEC   = 12'h305;
  localparam logic [11:0] CSR_MEPC    = 12'h341;
  localparam logic [11:0] CSR_MCAUSE  = 12'h342;

  localparam int MSTATUS_MIE_BIT  = 3;
  localparam int MSTATUS_MPIE_BIT = 7;
  localparam int MIE_MEIE_BIT     = 11;

  // Interrupt flag in bit 31, cause 11 = machine external interrupt.
  localparam logic [31:0] MCAUSE_EXT_INT = 32'h8000_000B;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_TRAP = 1'b1
  } int_state_t;

  // Instruction addresses are word aligned; the two low bits never hold state.
  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/sync_edge_det.sv
// Two-flop synchroniser followed by a rising-edge detector.
// Ports:
//   clk      - sampling clock
//   rst_n    - asynchronous active-low reset, clears all flops
//   async_in - level from another clock domain (or a pin)
//   rise     - one-cycle pulse when the synchronised level goes 0->1
module sync_edge_det (
  input  logic clk,
  input  logic rst_n,
  input  logic async_in,
  output logic rise
);

  logic sync_1;
  logic sync_2;
  logic sync_prev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_1    <= 1'b0;
      sync_2    <= 1'b0;
      sync_prev <= 1'b0;
    end else begin
      sync_1    <= async_in;
      sync_2    <= sync_1;
      sync_prev <= sync_2;
    end
  end

  assign rise = sync_2 & ~sync_prev;

endmodule

// File: rtl/csr_int_unit.sv
// Machine-mode CSR file and external-interrupt trap controller.
// Holds mstatus (MIE/MPIE), mie (MEIE), mtvec, mepc and optionally mcause;
// latches external interrupt edges as pending and raises a one-cycle
// int_taken pulse when the control FSM offers an instruction boundary.
// Optional feature macro: CSR_MCAUSE_EN (adds R/W mcause at 0x342).
//
// Ports:
//   clk       - sole clock
//   rst_n     - asynchronous active-low reset
//   intr      - external interrupt request, asynchronous
//   int_check - instruction-boundary pulse from the control FSM
//   pc_next   - address of the next instruction, saved to mepc on a trap
//   mret_exec - mret executing this cycle
//   csr_we    - CSR write enable
//   csr_addr  - CSR address
//   csr_wd    - CSR write data
//   csr_rd    - combinational CSR read data (0 for unimplemented addresses)
//   int_taken - one-cycle trap pulse
//   mtvec     - trap vector
//   mepc      - return address
//
// state | meaning
// ------+---------------------------------------------------------------
// RUN   | normal execution, waiting for a qualifying int_check
// TRAP  | trap accepted last cycle; int_taken high, back to RUN next cycle
module csr_int_unit
  import otter_csr_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        intr,
  input  logic        int_check,
  input  logic [31:0] pc_next,
  input  logic        mret_exec,
  input  logic        csr_we,
  input  logic [11:0] csr_addr,
  input  logic [31:0] csr_wd,
  output logic [31:0] csr_rd,
  output logic        int_taken,
  output logic [31:0] mtvec,
  output logic [31:0] mepc
);

  int_state_t  state;
  int_state_t  state_nx;

  logic        mst_mie;
  logic        mst_mpie;
  logic        mie_meie;
  logic [31:0] mtvec_q;
  logic [31:0] mepc_q;
  logic        pending;
  logic        intr_rise;
  logic        trap_go;

  logic        wr_mstatus;
  logic        wr_mie;
  logic        wr_mtvec;
  logic        wr_mepc;

  sync_edge_det u_sync_edge_det (
    .clk      (clk),
    .rst_n    (rst_n),
    .async_in (intr),
    .rise     (intr_rise)
  );

  assign wr_mstatus = csr_we && (csr_addr == CSR_MSTATUS);
  assign wr_mie     = csr_we && (csr_addr == CSR_MIE);
  assign wr_mtvec   = csr_we && (csr_addr == CSR_MTVEC);
  assign wr_mepc    = csr_we && (csr_addr == CSR_MEPC);

  // A boundary seen while already in TRAP is dropped, so back-to-back
  // int_check pulses cannot produce a two-cycle int_taken.
  assign trap_go = (state == ST_RUN) && int_check && pending && mst_mie && mie_meie;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_RUN;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx  = state;
    int_taken = 1'b0;
    case (state)
      ST_RUN: begin
        if (trap_go) begin
          state_nx = ST_TRAP;
        end
      end
      ST_TRAP: begin
        int_taken = 1'b1;
        state_nx  = ST_RUN;
      end
      default: begin
        state_nx = ST_RUN;
      end
    endcase
  end

  // A fresh edge in the same cycle as the clear must not be lost.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending <= 1'b0;
    end else if (intr_rise) begin
      pending <= 1'b1;
    end else if (trap_go) begin
      pending <= 1'b0;
    end
  end

  // Priority on mstatus: trap entry, then mret, then software write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mst_mie  <= 1'b0;
      mst_mpie <= 1'b0;
    end else if (trap_go) begin
      mst_mpie <= mst_mie;
      mst_mie  <= 1'b0;
    end else if (mret_exec) begin
      mst_mie  <= mst_mpie;
      mst_mpie <= 1'b1;
    end else if (wr_mstatus) begin
      mst_mie  <= csr_wd[MSTATUS_MIE_BIT];
      mst_mpie <= csr_wd[MSTATUS_MPIE_BIT];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mie_meie <= 1'b0;
    end else if (wr_mie) begin
      mie_meie <= csr_wd[MIE_MEIE_BIT];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mtvec_q <= '0;
    end else if (wr_mtvec) begin
      mtvec_q <= word_align(csr_wd);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mepc_q <= '0;
    end else if (trap_go) begin
      mepc_q <= word_align(pc_next);
    end else if (wr_mepc) begin
      mepc_q <= word_align(csr_wd);
    end
  end

`ifdef CSR_MCAUSE_EN
  logic        wr_mcause;
  logic [31:0] mcause_q;

  assign wr_mcause = csr_we && (csr_addr == CSR_MCAUSE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcause_q <= '0;
    end else if (trap_go) begin
      mcause_q <= MCAUSE_EXT_INT;
    end else if (wr_mcause) begin
      mcause_q <= csr_wd;
    end
  end
`endif

  always_comb begin
    csr_rd = '0;
    case (csr_addr)
      CSR_MSTATUS: begin
        csr_rd[MSTATUS_MIE_BIT]  = mst_mie;
        csr_rd[MSTATUS_MPIE_BIT] = mst_mpie;
      end
      CSR_MIE: begin
        csr_rd[MIE_MEIE_BIT] = mie_meie;
      end
      CSR_MTVEC: begin
        csr_rd = mtvec_q;
      end
      CSR_MEPC: begin
        csr_rd = mepc_q;
      end
`ifdef CSR_MCAUSE_EN
      CSR_MCAUSE: begin
        csr_rd = mcause_q;
      end
`endif
      default: begin
        csr_rd = '0;
      end
    endcase
  end

  assign mtvec = mtvec_q;
  assign mepc  = mepc_q;

endmodule

// File: doc/csr_int_unit.md
CSR_INT_UNIT -- requirements
Module: csr_int_unit

Interface
REQ-001 SHALL have port CLK, input, 1, sole clock; all state updates on rising edge.
REQ-002 SHALL have port RST_N, input, 1, reset, asynchronous, active-low.
REQ-003 SHALL have port INTR, input, 1, external interrupt request, asynchronous to CLK.
REQ-004 SHALL have port INT_CHECK, input, 1, one-cycle pulse from the control FSM at the instruction boundary.
REQ-005 SHALL have port PC_NEXT, input, 32, address of the next instruction to execute; captured into mepc on a trap.
REQ-006 SHALL have port MRET_EXEC, input, 1, mret executing this cycle (the decoder selects PC_SOURCE=5).
REQ-007 SHALL have port CSR_WE, input, 1, CSR write enable (csrrw).
REQ-008 SHALL have port CSR_ADDR, input, 12, CSR address.
REQ-009 SHALL have port CSR_WD, input, 32, CSR write data.
REQ-010 SHALL have port CSR_RD, output, 32, combinational read data for CSR_ADDR.
REQ-011 SHALL have port INT_TAKEN, output, 1, registered trap pulse, consumed by the decoder to force PC_SOURCE=4.
REQ-012 SHALL have port MTVEC, output, 32, trap vector.
REQ-013 SHALL have port MEPC, output, 32, return address.

Function
REQ-014 SHALL implement mstatus 0x300 (MIE bit 3, MPIE bit 7, other bits read 0), mie 0x304 (MEIE bit 11, other bits read 0), mtvec 0x305 (full 32 bits, bits[1:0] forced 0), and mepc 0x341 (full 32 bits, bits[1:0] forced 0).
REQ-015 SHALL return 0 on CSR_RD for any unimplemented address; SHALL ignore writes to unimplemented addresses.
REQ-016 SHALL synchronise INTR through two flops, then detect a rising edge on the synchronised signal.
REQ-017 SHALL set a sticky pending flag on each detected edge; the flag SHALL hold until a trap is taken.
REQ-018 SHALL use a two-state FSM: RUN and TRAP.
REQ-019 RUN->TRAP SHALL occur on a cycle where INT_CHECK=1, pending=1, mstatus.MIE=1 and mie.MEIE=1; otherwise the FSM SHALL stay in RUN.
REQ-020 On the RUN->TRAP edge the block SHALL update: mepc<=PC_NEXT, MPIE<=MIE, MIE<=0, pending<=0.
REQ-021 In TRAP, INT_TAKEN SHALL be 1 for exactly one cycle; TRAP->RUN SHALL follow unconditionally.
REQ-022 Latency SHALL be one cycle: INT_TAKEN rises in the cycle after the qualifying INT_CHECK.
REQ-023 On MRET_EXEC=1 the block SHALL update: MIE<=MPIE, MPIE<=1.
REQ-024 Simultaneous trap entry and CSR write to mstatus or mepc: the trap update SHALL win.
REQ-025 Simultaneous new edge and pending clear: pending SHALL remain 1.
REQ-026 Simultaneous MRET_EXEC and qualifying INT_CHECK: the trap SHALL win; MRET_EXEC SHALL be ignored.
REQ-027 INT_CHECK arriving while in TRAP SHALL be ignored.

Reset
REQ-028 RST_N low SHALL asynchronously clear every register (mstatus, mie, mtvec, mepc, synchroniser, pending, FSM=RUN, INT_TAKEN=0).
REQ-029 Reset asserted mid-TRAP SHALL drop INT_TAKEN immediately; state SHALL resume from RUN after release.

Configuration
REQ-030 With CSR_MCAUSE_EN defined: mcause 0x342 SHALL be implemented (R/W), reset 0, and SHALL load 32'h8000000B on trap entry.
REQ-031 With CSR_MCAUSE_EN undefined: address 0x342 SHALL read 0 and writes to it SHALL be ignored.

Structure
REQ-032 The CSR address constants and the FSM state enum SHALL live in a shared package, otter_csr_pkg.
REQ-033 The two-flop synchroniser with edge detect SHALL be a sub-module, sync_edge_det.

Verification
REQ-034 Enable an interrupt and accept it:
- Stimulus: write mstatus=0x8, mie=0x800, mtvec=0x100; pulse INTR; INT_CHECK with PC_NEXT=0x40.
- Response: INT_TAKEN one cycle; MEPC=0x40; CSR_RD(0x300)=0x80.
REQ-035 Return with mret: MRET_EXEC after the trap -> CSR_RD(0x300)=0x88.
REQ-036 Blocked interrupt stays pending:
- Stimulus: INTR pulse with MIE=0, INT_CHECK.
- Response: no INT_TAKEN.
- Then: write MIE=1 and INT_CHECK -> INT_TAKEN.
REQ-037 Trap beats CSR write: CSR write mepc=0x200 in the same cycle as a qualifying INT_CHECK with PC_NEXT=0x44 -> MEPC=0x44.
REQ-038 Reset mid-trap: RST_N low during TRAP -> INT_TAKEN=0 and all CSRs 0 within the same cycle.
REQ-039 mcause under CSR_MCAUSE_EN: build with CSR_MCAUSE_EN, take a trap -> CSR_RD(0x342)=0x8000000B; without the macro -> 0.
